proc_run_ctrl: RTL and testbench
================================

PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 SHALL provide parameter: PC_W, 64, program-counter width.
REQ-002 SHALL provide parameter: CYC_W, 32, cycle/instret counter width.
REQ-003 SHALL provide parameter: RST_CYCLES, 4, core reset hold length in cycles (>=1).
REQ-004 SHALL provide parameter: MAX_CYCLES, 10000, run timeout in cycles (< 2^CYC_W).
REQ-005 SHALL provide parameter: LOOP_LIMIT, 8, consecutive unchanged-PC cycles that count as self-loop halt.
REQ-006 SHALL provide parameter: HALT_INSN, 32'h00000073, instruction word that ends a run (ecall).
REQ-007 SHALL provide port: clk  input  1  single clock; all state on its rising edge.
REQ-008 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL provide port: start  input  1  begin a run (level sampled each cycle).
REQ-010 SHALL provide port: abort  input  1  cancel current run.
REQ-011 SHALL provide port: pc_out  input  PC_W  processor current PC.
REQ-012 SHALL provide port: instruction  input  32  processor fetched instruction.
REQ-013 SHALL provide port: core_reset  output  1  active-high reset to processor.
REQ-014 SHALL provide port: cycle_count  output  CYC_W  RUN cycles elapsed.
REQ-015 SHALL provide port: instret_count  output  CYC_W  PC-changing cycles in RUN.
REQ-016 SHALL provide port: done, pass, timeout  output  1 each  run status.
REQ-017 SHALL provide port: state  output  3  FSM state code.

Function
REQ-018 SHALL implement states IDLE=0, HOLD=1, RUN=2, DONE=3, TOUT=4; codes 5-7 unreachable, recover to IDLE next cycle.
REQ-019 IDLE: core_reset=1; start=1 -> HOLD next cycle.
REQ-020 HOLD: core_reset=1 for exactly RST_CYCLES cycles, then RUN; cycle_count, instret_count, pass, timeout, loop counter cleared on HOLD entry.
REQ-021 RUN: core_reset=0; cycle_count increments by 1 every RUN cycle, saturating at all-ones.
REQ-022 RUN: loop counter increments when pc_out equals previous-cycle pc_out, else clears to 0; first RUN cycle treats previous PC as unequal.
REQ-023 RUN exit priority, evaluated every cycle: abort -> IDLE; instruction==HALT_INSN -> DONE with pass=1; loop counter reaches LOOP_LIMIT-1 with PC still equal -> DONE with pass=0; cycle_count==MAX_CYCLES-1 -> TOUT with timeout=1.
REQ-024 Halt checks SHALL be ignored during HOLD (core PC undefined in reset).
REQ-025 done=1 in DONE and TOUT, 0 otherwise; core_reset=1 in DONE and TOUT (processor frozen).
REQ-026 DONE/TOUT sticky; counters and pass/timeout hold until start=1 -> HOLD (restart), or abort -> IDLE.
REQ-027 start SHALL be ignored in HOLD and RUN; abort in HOLD -> IDLE; abort in IDLE no effect.
REQ-028 Simultaneous start and abort SHALL resolve to abort.
REQ-029 All outputs registered; transitions take effect one cycle after the causing input sample.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, core_reset=1, all counters 0, done=0, pass=0, timeout=0, regardless of clk.
REQ-031 Release of reset SHALL not start a run; explicit start required.
REQ-032 reset asserted mid-RUN SHALL abandon the run with no DONE/TOUT indication.

Configuration
REQ-033 Macro RUN_CTRL_INSTRET_EN defined: instret_count increments in each RUN cycle where pc_out differs from previous-cycle pc_out, saturating at all-ones.
REQ-034 Macro RUN_CTRL_INSTRET_EN undefined: instret_count tied to 0, no counter register instantiated; all other behaviour identical.

Verification
REQ-035 reset=0 10 cycles, release, start=0 20 cycles -> state=0, core_reset=1, done=0 throughout.
REQ-036 start pulse, RST_CYCLES=4 -> core_reset=1 for 4 cycles after HOLD entry, then 0; HALT_INSN on instruction at RUN cycle 50 -> state=3, done=1, pass=1, cycle_count=50.
REQ-037 in RUN, pc_out frozen at 64'h40 for LOOP_LIMIT=8 cycles -> state=3, pass=0, core_reset=1.
REQ-038 MAX_CYCLES=100, PC increments by 4 each cycle, no halt -> state=4, timeout=1, cycle_count=100, instret_count=99 (macro on) / 0 (macro off).
REQ-039 abort asserted with start in RUN cycle 10 -> IDLE next cycle, done=0; then start alone -> HOLD, counters 0.
REQ-040 reset=0 asynchronously mid-RUN between clock edges -> outputs at reset values before next edge.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run controller for a processor under test: holds the core in reset, runs it, and detects
// ecall halt, PC self-loop and timeout. Define RUN_CTRL_INSTRET_EN to enable the instret counter.
module proc_run_ctrl #(
    parameter int unsigned PC_W       = 64,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned MAX_CYCLES = 10000,
    parameter int unsigned LOOP_LIMIT = 8,
    parameter logic [31:0] HALT_INSN  = 32'h0000_0073
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc_out,
    input  logic [31:0]      instruction,
    output logic             core_reset,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] instret_count,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_TOUT = 3'd4
    } state_e;

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_LIMIT + 1);

    localparam logic [HW-1:0]    HOLD_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]    LOOP_LAST = LW'(LOOP_LIMIT - 1);
    localparam logic [CYC_W-1:0] CYC_ONE   = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [LW-1:0]     loop_q, loop_d;
    logic [LW-1:0]     loop_inc_s;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic              prev_vld_q, prev_vld_d;
    logic              pass_q, pass_d;
    logic              tout_q, tout_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              clr_s;
    logic              pc_eq_s;
    logic              pc_ne_s;
    logic              loop_hit_s;

    // The first RUN cycle has no valid previous PC, so it is neither "equal" nor "changed".
    assign pc_eq_s    = prev_vld_q && (pc_out == prev_pc_q);
    assign pc_ne_s    = prev_vld_q && (pc_out != prev_pc_q);
    assign loop_inc_s = loop_q + LOOP_ONE;
    assign loop_hit_s = pc_eq_s && (loop_inc_s == LOOP_LAST);

`ifdef RUN_CTRL_INSTRET_EN
    logic [CYC_W-1:0] inst_q, inst_d;
`endif

    // Next-state, counter and status logic.
    always_comb begin
        state_d    = state_q;
        hold_d     = '0;
        loop_d     = loop_q;
        cyc_d      = cyc_q;
        prev_pc_d  = prev_pc_q;
        prev_vld_d = 1'b0;
        pass_d     = pass_q;
        tout_d     = tout_q;
        clr_s      = 1'b0;
`ifdef RUN_CTRL_INSTRET_EN
        inst_d     = inst_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_HOLD;
                    clr_s   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            S_RUN: begin
                cyc_d      = (cyc_q == '1) ? cyc_q : (cyc_q + CYC_ONE);
                prev_pc_d  = pc_out;
                prev_vld_d = 1'b1;
                if (pc_eq_s) begin
                    loop_d = (loop_q == '1) ? loop_q : loop_inc_s;
                end else begin
                    loop_d = '0;
                end
`ifdef RUN_CTRL_INSTRET_EN
                if (pc_ne_s && (inst_q != '1)) begin
                    inst_d = inst_q + CYC_ONE;
                end else begin
                    inst_d = inst_q;
                end
`endif
                if (abort) begin
                    state_d = S_IDLE;
                end else if (instruction == HALT_INSN) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (loop_hit_s) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = S_TOUT;
                    tout_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE, S_TOUT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_HOLD;
                    clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clr_s) begin
            loop_d = '0;
            cyc_d  = '0;
            pass_d = 1'b0;
            tout_d = 1'b0;
`ifdef RUN_CTRL_INSTRET_EN
            inst_d = '0;
`endif
        end else begin
            loop_d = loop_d;
        end

        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_DONE) || (state_d == S_TOUT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            loop_q     <= '0;
            cyc_q      <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            pass_q     <= 1'b0;
            tout_q     <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            loop_q     <= loop_d;
            cyc_q      <= cyc_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            pass_q     <= pass_d;
            tout_q     <= tout_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
        end
    end

`ifdef RUN_CTRL_INSTRET_EN
    // Retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q <= '0;
        end else begin
            inst_q <= inst_d;
        end
    end
    assign instret_count = inst_q;
`else
    assign instret_count = '0;
`endif

    assign state       = state_q;
    assign core_reset  = core_rst_q;
    assign cycle_count = cyc_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed self-checking bench for proc_run_ctrl (RST_CYCLES=4, LOOP_LIMIT=8, MAX_CYCLES=100).
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [63:0] pc_out;
    logic [31:0] instruction;
    logic        core_reset;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0073;

    proc_run_ctrl #(
        .PC_W(64), .CYC_W(32), .RST_CYCLES(4), .MAX_CYCLES(100),
        .LOOP_LIMIT(8), .HALT_INSN(32'h0000_0073)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pc_out(pc_out), .instruction(instruction),
        .core_reset(core_reset), .cycle_count(cycle_count),
        .instret_count(instret_count), .done(done), .pass(pass),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] inst_exp(input int n);
`ifdef RUN_CTRL_INSTRET_EN
        return 64'(n);
`else
        return (n > 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    // Enter HOLD via start and step through the 4 hold cycles into RUN.
    task automatic start_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_hold_cyc"}, 64'(cycle_count), 64'd0);
        chk({tag, "_hold_ins"}, 64'(instret_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_hold_st"}, 64'(state), 64'd1);
            chk({tag, "_hold_crst"}, 64'(core_reset), 64'd1);
            tick();
        end
        chk({tag, "_run_st"}, 64'(state), 64'd2);
        chk({tag, "_run_crst"}, 64'(core_reset), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        pc_out = 64'h0; instruction = NOP;
        #2;
        chk("rst_async_st", 64'(state), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("rst_st", 64'(state), 64'd0);
        chk("rst_crst", 64'(core_reset), 64'd1);
        chk("rst_cyc", 64'(cycle_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_st", 64'(state), 64'd0);
            chk("idle_crst", 64'(core_reset), 64'd1);
            chk("idle_done", 64'(done), 64'd0);
        end

        // Halt on ecall at RUN cycle 50; ecall during HOLD must be ignored.
        pc_out = 64'h1000;
        instruction = HALT;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("h_hold_st", 64'(state), 64'd1);
            chk("h_hold_crst", 64'(core_reset), 64'd1);
            tick();
        end
        chk("h_run_st", 64'(state), 64'd2);
        chk("h_run_crst", 64'(core_reset), 64'd0);
        instruction = NOP;
        for (int k = 1; k <= 49; k++) begin
            pc_out = 64'h1000 + 64'(4 * k);
            tick();
            if (k == 1) chk("h_cyc1", 64'(cycle_count), 64'd1);
            if (k == 10) chk("h_cyc10", 64'(cycle_count), 64'd10);
        end
        chk("h_pre_st", 64'(state), 64'd2);
        chk("h_pre_done", 64'(done), 64'd0);
        pc_out = 64'h1000 + 64'd200;
        instruction = HALT;
        tick();
        instruction = NOP;
        chk("h_st", 64'(state), 64'd3);
        chk("h_done", 64'(done), 64'd1);
        chk("h_pass", 64'(pass), 64'd1);
        chk("h_cyc", 64'(cycle_count), 64'd50);
        chk("h_ins", 64'(instret_count), inst_exp(49));
        chk("h_crst", 64'(core_reset), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("h_sticky_st", 64'(state), 64'd3);
        chk("h_sticky_cyc", 64'(cycle_count), 64'd50);
        chk("h_sticky_pass", 64'(pass), 64'd1);

        // Self-loop: PC frozen at 0x40 for 8 RUN cycles.
        pc_out = 64'h40;
        start_run("loop");
        chk("loop_pass0", 64'(pass), 64'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("loop_run_st", 64'(state), 64'd2);
        end
        tick();
        chk("loop_st", 64'(state), 64'd3);
        chk("loop_pass", 64'(pass), 64'd0);
        chk("loop_done", 64'(done), 64'd1);
        chk("loop_crst", 64'(core_reset), 64'd1);
        chk("loop_cyc", 64'(cycle_count), 64'd8);
        chk("loop_ins", 64'(instret_count), 64'd0);

        // Abort from DONE, then timeout with PC stepping by 4.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done_st", 64'(state), 64'd0);
        chk("ab_done_done", 64'(done), 64'd0);
        pc_out = 64'h2000;
        start_run("to");
        for (int k = 1; k <= 99; k++) begin
            pc_out = 64'h2000 + 64'(4 * k);
            tick();
        end
        chk("to_pre_st", 64'(state), 64'd2);
        chk("to_pre_cyc", 64'(cycle_count), 64'd99);
        chk("to_pre_tout", 64'(timeout), 64'd0);
        pc_out = 64'h2000 + 64'd400;
        tick();
        chk("to_st", 64'(state), 64'd4);
        chk("to_tout", 64'(timeout), 64'd1);
        chk("to_done", 64'(done), 64'd1);
        chk("to_pass", 64'(pass), 64'd0);
        chk("to_cyc", 64'(cycle_count), 64'd100);
        chk("to_ins", 64'(instret_count), inst_exp(99));
        chk("to_crst", 64'(core_reset), 64'd1);

        // Restart from TOUT, abort+start in RUN cycle 10.
        start_run("ab");
        chk("ab_tout_clr", 64'(timeout), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            pc_out = 64'h3000 + 64'(4 * k);
            tick();
        end
        chk("ab_cyc9", 64'(cycle_count), 64'd9);
        start = 1'b1; abort = 1'b1;
        tick();
        chk("ab_st", 64'(state), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        chk("ab_crst", 64'(core_reset), 64'd1);
        tick();
        chk("ab_idle_both_st", 64'(state), 64'd0);
        abort = 1'b0;
        tick();
        start = 1'b0;
        chk("ab_restart_st", 64'(state), 64'd1);
        chk("ab_restart_cyc", 64'(cycle_count), 64'd0);
        chk("ab_restart_ins", 64'(instret_count), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_hold_st", 64'(state), 64'd0);

        // Start ignored in RUN, then async reset between edges.
        start_run("ign");
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pc_out = 64'h4000 + 64'(4 * k);
            tick();
        end
        start = 1'b0;
        chk("ign_st", 64'(state), 64'd2);
        chk("ign_cyc", 64'(cycle_count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_st", 64'(state), 64'd0);
        chk("ar_crst", 64'(core_reset), 64'd1);
        chk("ar_cyc", 64'(cycle_count), 64'd0);
        chk("ar_ins", 64'(instret_count), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("ar_rel_st", 64'(state), 64'd0);
        chk("ar_rel_done", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
